// File: rtl/unpacker_pkg.sv
// Shared types and sizing for the activation unpacker.
package unpacker_pkg;
   localparam int IO_DATA_WIDTH    = 8;
   localparam int MEM_BW           = 128;
   localparam int LANES            = MEM_BW / IO_DATA_WIDTH;
   localparam int ADDR_WIDTH_ACT   = 14;
   localparam int ADDR_WIDTH_MASKS = 11;
   localparam int MASKS_PER_WORD   = 8;
   localparam int BUFFER_BYTES     = 32;
   localparam int FILL_W           = 6;
   localparam int CNT_W            = 5;

   typedef enum logic [2:0] {
      IDLE, MASK_REQ, MASK_WAIT, CHECK, ACT_REQ, ACT_WAIT, EMIT, DONE
   } fsm_state;
endpackage

// File: rtl/unpacker_if.sv
// Control, memory-read and output-stream signals of the unpacker.
interface unpacker_if;
   import unpacker_pkg::*;

   logic                        start_unpacker;
   logic                        ready_unpacker;
   logic                        done_unpacker;
   logic [15:0]                 num_words;
   logic [ADDR_WIDTH_ACT-1:0]   act_base_addr;
   logic [ADDR_WIDTH_MASKS-1:0] masks_base_addr;
   logic                        act_read_req;
   logic [ADDR_WIDTH_ACT-1:0]   act_read_addr;
   logic [MEM_BW-1:0]           act_rdata;
   logic                        masks_read_req;
   logic [ADDR_WIDTH_MASKS-1:0] masks_read_addr;
   logic [MEM_BW-1:0]           masks_rdata;
   logic                        out_valid;
   logic                        out_ready;
   logic [MEM_BW-1:0]           decoded_out;

   modport master (
      input  start_unpacker, num_words, act_base_addr, masks_base_addr,
             act_rdata, masks_rdata, out_ready,
      output ready_unpacker, done_unpacker, act_read_req, act_read_addr,
             masks_read_req, masks_read_addr, out_valid, decoded_out
   );

   modport slave (
      output start_unpacker, num_words, act_base_addr, masks_base_addr,
             act_rdata, masks_rdata, out_ready,
      input  ready_unpacker, done_unpacker, act_read_req, act_read_addr,
             masks_read_req, masks_read_addr, out_valid, decoded_out
   );
endinterface

// File: rtl/unpacker_prefix_popcount.sv
// Per-lane exclusive prefix count of set mask bits plus total popcount.
module prefix_popcount
   import unpacker_pkg::*;
(
   input  logic [LANES-1:0] mask,
   output logic [CNT_W-1:0] prefix [LANES],
   output logic [CNT_W-1:0] total
);

   always_comb begin
      logic [CNT_W-1:0] acc;
      acc = '0;
      // Lane i is governed by mask bit (LANES-1-i).
      for (int unsigned i = 0; i < LANES; i++) begin
         prefix[i] = acc;
         acc       = acc + CNT_W'(mask[LANES-1-i]);
      end
      total = acc;
   end

endmodule

// File: rtl/unpacker.sv
// Re-expands mask + packed nonzero bytes into full activation words and
// streams them out over valid/ready.
module unpacker
   import unpacker_pkg::*;
(
   input  logic      clk,
   input  logic      arst_in,
   unpacker_if.master bus
);

   fsm_state                    state;
   logic [7:0]                  buffer [BUFFER_BYTES];
   logic [FILL_W-1:0]           fill;
   logic [MEM_BW-1:0]           mask_word;
   logic [2:0]                  mask_idx;
   logic [15:0]                 words_done;
   logic [15:0]                 num_words_r;
   logic [ADDR_WIDTH_ACT-1:0]   act_ptr;
   logic [ADDR_WIDTH_MASKS-1:0] mask_ptr;
   logic                        ready_r, done_r, valid_r, act_req_r, mask_req_r;

   logic [LANES-1:0]            cur_mask;
   logic [CNT_W-1:0]            prefix [LANES];
   logic [CNT_W-1:0]            pc;
   logic [MEM_BW-1:0]           expanded;

   // The active mask always sits in the top 16 bits; consumed masks shift out.
   assign cur_mask = mask_word[MEM_BW-1 -: LANES];

   prefix_popcount u_prefix (
      .mask   (cur_mask),
      .prefix (prefix),
      .total  (pc)
   );

   always_comb begin
      expanded = '0;
      for (int unsigned i = 0; i < LANES; i++) begin
         if (cur_mask[LANES-1-i])
            expanded[MEM_BW-1-IO_DATA_WIDTH*i -: IO_DATA_WIDTH] = buffer[prefix[i]];
      end
   end

   assign bus.ready_unpacker  = ready_r;
   assign bus.done_unpacker   = done_r;
   assign bus.out_valid       = valid_r;
   assign bus.decoded_out     = valid_r ? expanded : '0;
   assign bus.act_read_req    = act_req_r;
   assign bus.act_read_addr   = act_ptr;
   assign bus.masks_read_req  = mask_req_r;
   assign bus.masks_read_addr = mask_ptr;

   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         state       <= IDLE;
         ready_r     <= 1'b1;
         done_r      <= 1'b0;
         valid_r     <= 1'b0;
         act_req_r   <= 1'b0;
         mask_req_r  <= 1'b0;
         fill        <= '0;
         mask_word   <= '0;
         mask_idx    <= '0;
         words_done  <= '0;
         num_words_r <= '0;
         act_ptr     <= '0;
         mask_ptr    <= '0;
         for (int unsigned j = 0; j < BUFFER_BYTES; j++) buffer[j] <= '0;
      end else begin
         // Outputs are registered: each transition sets the flags of the state it enters.
         ready_r    <= 1'b0;
         done_r     <= 1'b0;
         valid_r    <= 1'b0;
         act_req_r  <= 1'b0;
         mask_req_r <= 1'b0;
         case (state)
            IDLE: begin
               ready_r <= 1'b1;
               if (bus.start_unpacker) begin
                  ready_r     <= 1'b0;
                  num_words_r <= bus.num_words;
                  act_ptr     <= bus.act_base_addr;
                  mask_ptr    <= bus.masks_base_addr;
                  fill        <= '0;
                  mask_idx    <= '0;
                  words_done  <= '0;
                  if (bus.num_words == '0) begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end else begin
                     state      <= MASK_REQ;
                     mask_req_r <= 1'b1;
                  end
               end
            end
            MASK_REQ: state <= MASK_WAIT;
            MASK_WAIT: begin
               mask_word <= bus.masks_rdata;
               mask_ptr  <= mask_ptr + ADDR_WIDTH_MASKS'(1);
               mask_idx  <= '0;
               state     <= CHECK;
            end
            CHECK: begin
               if (fill < FILL_W'(pc)) begin
                  state     <= ACT_REQ;
                  act_req_r <= 1'b1;
               end else begin
                  state   <= EMIT;
                  valid_r <= 1'b1;
               end
            end
            ACT_REQ: state <= ACT_WAIT;
            ACT_WAIT: begin
               // Refill only happens with fill < pc <= 16, so fill+15 stays in range.
               for (int unsigned j = 0; j < LANES; j++)
                  buffer[5'(32'(fill) + j)] <= bus.act_rdata[MEM_BW-1-IO_DATA_WIDTH*j -: IO_DATA_WIDTH];
               fill    <= fill + FILL_W'(16);
               act_ptr <= act_ptr + ADDR_WIDTH_ACT'(1);
               state   <= EMIT;
               valid_r <= 1'b1;
            end
            EMIT: begin
               if (bus.out_ready) begin
                  for (int unsigned j = 0; j < BUFFER_BYTES; j++)
                     buffer[j] <= (j + 32'(pc) < BUFFER_BYTES) ? buffer[5'(j + 32'(pc))] : '0;
                  fill       <= fill - FILL_W'(pc);
                  words_done <= words_done + 16'd1;
                  mask_word  <= mask_word << LANES;
                  if (words_done + 16'd1 == num_words_r) begin
                     state  <= DONE;
                     done_r <= 1'b1;
                  end else if (mask_idx == 3'(MASKS_PER_WORD-1)) begin
                     state      <= MASK_REQ;
                     mask_req_r <= 1'b1;
                  end else begin
                     mask_idx <= mask_idx + 3'd1;
                     state    <= CHECK;
                  end
               end else begin
                  valid_r <= 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               ready_r <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/unpacker.md
Name: unpacker

Overview:
- Decompression counterpart of the activation packer.
- Reads mask words and densely packed encoded-byte words from the activation and mask memories.
- Re-expands each 16-bit mask plus its nonzero bytes into a full 128-bit activation word (zero lanes restored) and streams the words out over a valid/ready handshake.
- Sits between the activation/mask SRAMs and the PE-array input path.

Parameters:
- IO_DATA_WIDTH, 8: width of one activation lane (byte).
- MEM_BW, 128: memory word width; LANES = MEM_BW/IO_DATA_WIDTH = 16.
- ADDR_WIDTH_ACT, 14: encoded activation memory address width.
- ADDR_WIDTH_MASKS, 11: mask memory address width.

Ports:
- clk  in  1  clock.
- arst_in  in  1  asynchronous reset, active-high.
- start_unpacker  in  1  start pulse; sampled only in IDLE.
- ready_unpacker  out  1  high in IDLE.
- done_unpacker  out  1  one-cycle pulse when the block is finished.
- num_words  in  16  number of output words in the block; latched on start.
- act_base_addr  in  ADDR_WIDTH_ACT  first encoded word address; latched on start.
- masks_base_addr  in  ADDR_WIDTH_MASKS  first mask word address; latched on start.
- act_read_req  out  1  encoded-memory read strobe.
- act_read_addr  out  ADDR_WIDTH_ACT  encoded-memory read address.
- act_rdata  in  MEM_BW  encoded-memory data, valid the cycle after the request.
- masks_read_req  out  1  mask-memory read strobe.
- masks_read_addr  out  ADDR_WIDTH_MASKS  mask-memory read address.
- masks_rdata  in  MEM_BW  mask-memory data, valid the cycle after the request.
- out_valid  out  1  decoded word valid.
- out_ready  in  1  consumer accepts.
- decoded_out  out  MEM_BW  expanded activation word.

Behaviour:
- Format:
  - Lane i is bits [MEM_BW-1-8i -: 8] (lane 0 at the MSB).
  - One mask word holds 8 masks; mask k is bits [MEM_BW-1-16k -: 16].
  - Mask bit (15-i) set means lane i is nonzero.
  - Encoded words hold the nonzero bytes in order, first byte at lane 0. They are continuous across words; the final word is zero-padded.
- Buffer:
  - 32-byte buffer, byte 0 oldest; fill counter 6 bits (0..32).
  - pc = popcount of the current mask (0..16).
- Expansion (combinational): decoded lane i = buffer[prefix_i] if mask bit (15-i) is set, else 0. prefix_i = number of set mask bits for lanes 0..i-1.
- FSM states: IDLE, MASK_REQ, MASK_WAIT, CHECK, ACT_REQ, ACT_WAIT, EMIT, DONE.
  - IDLE: ready_unpacker=1. On start, latch inputs and clear fill, mask_idx and words_done. num_words==0 goes to DONE with no reads; otherwise go to MASK_REQ.
  - MASK_REQ: masks_read_req=1, masks_read_addr=mask_ptr. Go to MASK_WAIT.
  - MASK_WAIT: capture masks_rdata, mask_ptr++, mask_idx=0. Go to CHECK.
  - CHECK: if fill < pc go to ACT_REQ, else go to EMIT.
  - ACT_REQ: act_read_req=1, act_read_addr=act_ptr. Go to ACT_WAIT.
  - ACT_WAIT: write the 16 bytes of act_rdata at buffer[fill..fill+15], fill+=16, act_ptr++. Go to EMIT.
  - EMIT: out_valid=1.
    - On out_ready: shift the buffer left by pc bytes (zero-fill), fill-=pc, words_done++.
    - Then, if words_done+1==num_words, go to DONE.
    - Else if mask_idx==7, go to MASK_REQ.
    - Else mask_idx++ and go to CHECK.
  - DONE: done_unpacker=1. Go to IDLE.
- Fetch rules:
  - Encoded words are fetched only on demand (fill < pc), so no read ever goes past the packed stream.
  - After a refill, fill >= 16 >= pc always holds.
  - Mask words are fetched only when needed; a partial last mask word is legal.
- Backpressure: while out_valid && !out_ready, decoded_out, buffer, pointers and counters are held stable.
- Reset (any time, including mid-fetch or mid-EMIT): state goes to IDLE.
  - All regs clear; fill=0.
  - out_valid, act_read_req, masks_read_req and done_unpacker are 0; decoded_out is 0.
  - ready_unpacker is 1.
- start while busy is ignored. Address pointers wrap modulo 2^width.

Decomposition:
- Package unpacker_pkg: fsm_state enum, LANES, MASKS_PER_WORD=8, BUFFER_BYTES=32.
- Sub-module prefix_popcount: 16-bit mask in, 16 prefix counts (5 b each) plus total pc out. Reused by the expansion mux.

Test Plan:
1. All masks 0xFFFF, num_words=2, encoded words bytes 0x00..0x0F and 0x10..0x1F -> outputs identical to those words; 1 mask read at base, 2 act reads at base and base+1; done pulse.
2. Masks 0x8001 x8, encoded word A,B,C,...,P -> out0 lane0=A, lane15=B, others 0; out7 lane0=O, lane15=P; exactly 1 act read.
3. Straddle: masks 0xFFF0 then 0xFFF0, num_words=2 -> second output lanes0..3 = encoded word0 bytes 12..15, lanes4..11 = word1 bytes 0..7, lanes 12..15 = 0; second act read issued only before the second output.
4. num_words=16, all masks 0x0000 -> 16 zero words; mask reads at masks_base, masks_base+1; zero act reads.
5. Hold out_ready=0 for 5 cycles mid-stream -> out_valid stays 1 with decoded_out unchanged; no memory requests issued.
6. num_words=0 -> done_unpacker pulses one cycle after start with no reads. Separately, assert arst_in during EMIT -> out_valid=0 immediately, ready_unpacker=1; a fresh start decodes correctly.
